// File: rtl/hamming_encoder.sv
// rtl/hamming_encoder.sv - registered Hamming(7,4) encoder with valid flag
//
// Purpose:
//   Encodes a 4-bit data word into a 7-bit Hamming(7,4) codeword.
//   The output is registered, so a codeword appears one clock after the
//   data word is presented. A new word can be accepted every cycle.
//   When select is low at a clock edge, the output register is cleared
//   and the valid flag drops.
//
// Parameters:
//   PARITY_ODD  0 = even parity bits (standard Hamming), 1 = every parity bit inverted
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset; clears b and b_valid
//   select   in   1  encode enable: 1 = encode a this cycle, 0 = clear the output
//   a        in   4  data word: a[0]=d1, a[1]=d2, a[2]=d3, a[3]=d4
//   b        out  7  codeword: b[k-1] holds Hamming position k
//   b_valid  out  1  high while b holds a codeword encoded from a sampled a

module hamming_encoder #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select,
  input  logic [3:0] a,
  output logic [6:0] b,
  output logic       b_valid
);

  logic       p1;
  logic       p2;
  logic       p3;
  logic [6:0] codeword;

  // Each parity bit covers the positions whose index has the matching bit set:
  //   p1 covers positions 3,5,7 (d1,d2,d4)
  //   p2 covers positions 3,6,7 (d1,d3,d4)
  //   p3 covers positions 5,6,7 (d2,d3,d4)
  // With this coverage, the syndrome of a single-bit error equals the
  // position of the flipped bit.
  always_comb begin
    p1       = a[0] ^ a[1] ^ a[3] ^ PARITY_ODD;
    p2       = a[0] ^ a[2] ^ a[3] ^ PARITY_ODD;
    p3       = a[1] ^ a[2] ^ a[3] ^ PARITY_ODD;
    codeword = {a[3], a[2], a[1], p3, a[0], p2, p1};
  end

  // When select is low, the output is loaded with a constant zero rather
  // than a gated codeword. This keeps an undriven or unknown a from
  // reaching b.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b       <= 7'b0;
      b_valid <= 1'b0;
    end else if (select) begin
      b       <= codeword;
      b_valid <= 1'b1;
    end else begin
      b       <= 7'b0;
      b_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_encoder.sv
// tb/tb_hamming_encoder.sv - directed and exhaustive check of hamming_encoder (even and odd parity)

module tb_hamming_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       select;
  logic [3:0] a;
  logic [6:0] b_e;
  logic       v_e;
  logic [6:0] b_o;
  logic       v_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming_encoder #(.PARITY_ODD(1'b0)) dut_even (
    .clk     (clk),
    .rst     (rst),
    .select  (select),
    .a       (a),
    .b       (b_e),
    .b_valid (v_e)
  );

  hamming_encoder #(.PARITY_ODD(1'b1)) dut_odd (
    .clk     (clk),
    .rst     (rst),
    .select  (select),
    .a       (a),
    .b       (b_o),
    .b_valid (v_o)
  );

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reference encoder: place the data bits at positions 3,5,6,7, then choose
  // each parity bit k so that its covered positions XOR to zero (or one,
  // for odd parity).
  function automatic logic [6:0] model(input logic [3:0] d, input logic odd);
    logic [7:1] pos;
    logic [2:0] idx;
    pos    = '0;
    pos[3] = d[0];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int i = 0; i < 3; i++) begin
      logic par;
      par = odd;
      for (int k = 3; k <= 7; k++) begin
        idx = 3'(k);
        if (idx[i]) par ^= pos[k];
      end
      pos[1 << i] = par;
    end
    return pos;
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    logic [2:0] s;
    s = 3'd0;
    for (int k = 1; k <= 7; k++)
      if (cw[k-1]) s ^= 3'(k);
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    select = 1'b1;
    a      = 4'hF;

    // Reset holds both outputs at zero while the clock keeps running.
    #1;
    check("reset_b_t0", b_e, 7'b0);
    check("reset_v_t0", {6'b0, v_e}, 7'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_b", b_e, 7'b0);
      check("reset_v", {6'b0, v_e}, 7'b0);
      check("reset_b_odd", b_o, 7'b0);
    end

    // With select low, the output is cleared.
    rst    = 1'b0;
    select = 1'b0;
    a      = 4'b1000;
    tick();
    check("gate_b", b_e, 7'b0);
    check("gate_v", {6'b0, v_e}, 7'b0);
    check("gate_b_odd", b_o, 7'b0);

    // Directed encodes with hand-computed codewords.
    select = 1'b1;
    a      = 4'b1000;
    tick();
    check("enc_1000", b_e, 7'b1001011);
    check("enc_1000_v", {6'b0, v_e}, 7'b1);
    a = 4'b0001;
    tick();
    check("enc_0001", b_e, 7'b0000111);
    a = 4'b0000;
    tick();
    check("enc_0000", b_e, 7'b0000000);
    check("enc_0000_v", {6'b0, v_e}, 7'b1);
    check("odd_0000", b_o, 7'b0001011);
    check("odd_0000_v", {6'b0, v_o}, 7'b1);
    a = 4'b1111;
    tick();
    check("enc_1111", b_e, 7'b1111111);
    a = 4'b0110;
    tick();
    check("enc_0110", b_e, 7'b0110011);

    // Unknown data with select low must still produce zero.
    select = 1'b0;
    a      = 4'bxxxx;
    tick();
    check("x_gate_b", b_e, 7'b0);
    check("x_gate_v", {6'b0, v_e}, 7'b0);

    // All 16 data words back-to-back; each result is checked one cycle later.
    select = 1'b1;
    a      = 4'd0;
    for (int i = 0; i < 16; i++) begin
      logic [6:0] exp_e;
      logic [3:0] d;
      d     = 4'(i);
      exp_e = model(d, 1'b0);
      tick();
      a = 4'(i + 1);
      check($sformatf("exh_even_%0d", i), b_e, exp_e);
      check($sformatf("exh_odd_%0d", i), b_o, model(d, 1'b1));
      check($sformatf("exh_v_%0d", i), {6'b0, v_e}, 7'b1);
      check($sformatf("syn0_%0d", i), {4'b0, syndrome(b_e)}, 7'b0);
      for (int k = 1; k <= 7; k++) begin
        logic [6:0] flipped;
        flipped = b_e ^ (7'b1 << (k - 1));
        check($sformatf("syn_%0d_flip%0d", i, k), {4'b0, syndrome(flipped)}, 7'(k));
      end
    end

    // A reset pulse in mid-stream clears the outputs without waiting for a clock edge.
    a = 4'b1000;
    tick();
    check("pre_rst_b", b_e, 7'b1001011);
    rst = 1'b1;
    #1;
    check("async_rst_b", b_e, 7'b0);
    check("async_rst_v", {6'b0, v_e}, 7'b0);
    check("async_rst_b_odd", b_o, 7'b0);
    #2;
    rst = 1'b0;
    a   = 4'b0110;
    #1;
    check("post_rst_hold", b_e, 7'b0);
    tick();
    check("post_rst_enc", b_e, 7'b0110011);
    check("post_rst_v", {6'b0, v_e}, 7'b1);
    check("post_rst_odd", b_o, model(4'b0110, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
